gsim_bgen: RTL and testbench

- Forward-model companion to the Gauss-Seidel solver: computes b = A·x for the fixed 16x16 banded solver matrix.
- A has diagonal 20, offsets ±1 = -13, ±2 = +6, ±3 = -1, and is truncated at the edges.
- Accepts 16 solution values x (as emitted by the solver, signed Q16.16) serially and emits 16 right-hand-side values b (signed 16-bit integer) serially.
- Used to regenerate stimulus from golden x and to check solver residuals in closed loop.

---
 rtl/gsim_bgen.sv | 112 +++++++++++
 tb/tb_gsim_bgen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gsim_bgen.sv
// rtl/gsim_bgen.sv - forward model b = A*x for the 16x16 banded Gauss-Seidel matrix
module gsim_bgen #(
  parameter int N  = 16,
  parameter int XW = 32,
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_en,
  input  logic [XW-1:0] x_in,
  output logic          in_ready,
  output logic          out_valid,
  output logic [BW-1:0] b_out
);

  localparam int LW = $clog2(N);
  // Accumulator width: 20*x plus three pair sums cannot exceed 60*2^31.
  localparam int SW = XW + 6;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  state_t               state, state_nxt;
  logic [LW-1:0]        load_cnt;
  logic [LW-1:0]        out_cnt;
  logic signed [XW-1:0] xbuf [N];
  logic                 load_fire;

  logic signed [XW-1:0] xm3, xm2, xm1, x0, xp1, xp2, xp3;
  logic signed [XW:0]   p1, p2, p3;
  logic signed [SW-1:0] s, r_full;
  logic [BW-1:0]        b_sat;

  assign load_fire = in_en & in_ready;

  // Band tap: indices outside 0..N-1 read as zero (edge truncation, no wrap).
  function automatic logic signed [XW-1:0] tap(input int idx);
    logic [31:0] uidx;
    uidx = idx;
    if (idx < 0 || idx > N - 1) return '0;
    return xbuf[uidx[LW-1:0]];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: IDLE -> LOAD -> CALC -> OUT -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_en) state_nxt = LOAD;
      LOAD: if (in_en && load_cnt == LW'(N - 1)) state_nxt = CALC;
      CALC: state_nxt = OUT;
      OUT:  if (out_cnt == LW'(N - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: accept input only while collecting a frame.
  always_comb begin
    in_ready = 1'b0;
    if (state == IDLE || state == LOAD) in_ready = 1'b1;
  end

  // Combinational MAC for the row selected by out_cnt, rounded and saturated.
  always_comb begin
    int ci;
    ci  = int'({{(32-LW){1'b0}}, out_cnt});
    xm3 = tap(ci - 3);
    xm2 = tap(ci - 2);
    xm1 = tap(ci - 1);
    x0  = tap(ci);
    xp1 = tap(ci + 1);
    xp2 = tap(ci + 2);
    xp3 = tap(ci + 3);
    p1  = (XW+1)'(xm1) + (XW+1)'(xp1);
    p2  = (XW+1)'(xm2) + (XW+1)'(xp2);
    p3  = (XW+1)'(xm3) + (XW+1)'(xp3);
    s   = SW'(x0) * SW'(20) - SW'(p1) * SW'(13) + SW'(p2) * SW'(6) - SW'(p3);
    // Adding half an LSB then flooring gives round-half-toward-+inf.
    r_full = (s + (SW'(1) <<< 15)) >>> 16;
    if (r_full > SW'(32767))       b_sat = 16'h7FFF;
    else if (r_full < -SW'(32768)) b_sat = 16'h8000;
    else                           b_sat = r_full[BW-1:0];
  end

  // Datapath: x capture, counters, and registered result stream.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt  <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      b_out     <= '0;
      for (int k = 0; k < N; k++) xbuf[k] <= '0;
    end else begin
      if (load_fire) begin
        xbuf[load_cnt] <= x_in;
        load_cnt       <= (load_cnt == LW'(N - 1)) ? '0 : load_cnt + 1'b1;
      end
      out_valid <= (state == OUT);
      if (state == OUT) begin
        b_out   <= b_sat;
        out_cnt <= out_cnt + 1'b1;
      end else begin
        out_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gsim_bgen.sv
// tb/tb_gsim_bgen.sv - directed self-checking bench for gsim_bgen
module tb_gsim_bgen;

  typedef logic [31:0] frame_t [16];
  typedef int          exp_t   [16];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_en = 1'b0;
  logic [31:0] x_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] b_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int got[$];
  int gcyc[$];

  gsim_bgen dut (
    .clk(clk), .reset(reset), .in_en(in_en), .x_in(x_in),
    .in_ready(in_ready), .out_valid(out_valid), .b_out(b_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid) begin
      got.push_back(int'($signed(b_out)));
      gcyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns the cycle of the edge that took x_15.
  task automatic send_frame(input frame_t xs, input int gap_at, input int gap_len,
                            output int acc);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("wait_in_ready", int'(in_ready), 1);
    for (int k = 0; k < 16; k++) begin
      in_en = 1'b1;
      x_in  = xs[k];
      @(posedge clk); #1;
      if (k == gap_at) begin
        in_en = 1'b0;
        x_in  = 32'hDEAD_BEEF;
        repeat (gap_len) begin
          @(posedge clk); #1;
        end
      end
    end
    acc   = cyc;
    in_en = 1'b0;
    x_in  = '0;
  endtask

  task automatic expect_frame(input exp_t ex, input string name, input int acc);
    int t;
    t = 0;
    while (got.size() < 16 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (got.size() < 16) begin
      check({name, "_timeout"}, got.size(), 16);
    end else begin
      check({name, "_latency"}, gcyc[0] - acc, 2);
      check({name, "_contig"}, gcyc[15] - gcyc[0], 15);
      for (int k = 0; k < 16; k++)
        check($sformatf("%s_b%0d", name, k), got[k], ex[k]);
      repeat (16) begin
        void'(got.pop_front());
        void'(gcyc.pop_front());
      end
    end
  endtask

  exp_t e_ones  = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
  exp_t e_unit  = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
  exp_t e_half  = '{10, -6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  exp_t e_pos   = '{32767, -26000, 12000, -2000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  exp_t e_neg   = '{-32768, 26000, -12000, 2000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    frame_t f_ones, f_unit, f_half, f_pos, f_neg;
    int acc, acc1, acc2, t;

    for (int k = 0; k < 16; k++) begin
      f_ones[k] = 32'h0001_0000;
      f_unit[k] = '0;
      f_half[k] = '0;
      f_pos[k]  = '0;
      f_neg[k]  = '0;
    end
    f_unit[5] = 32'h0001_0000;
    f_half[0] = 32'h0000_8000;
    f_pos[0]  = 32'h07D0_0000;
    f_neg[0]  = 32'hF830_0000;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_b_out", int'(b_out), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // All ones.
    send_frame(f_ones, -1, 0, acc);
    expect_frame(e_ones, "ones", acc);

    // Unit column at index 5.
    send_frame(f_unit, -1, 0, acc);
    expect_frame(e_unit, "unit", acc);

    // Rounding of half values.
    send_frame(f_half, -1, 0, acc);
    expect_frame(e_half, "round", acc);

    // Saturation both directions.
    send_frame(f_pos, -1, 0, acc);
    expect_frame(e_pos, "satpos", acc);
    send_frame(f_neg, -1, 0, acc);
    expect_frame(e_neg, "satneg", acc);

    // Gap of 3 idle cycles after x_7.
    send_frame(f_ones, 7, 3, acc);
    expect_frame(e_ones, "gap", acc);

    // in_en pulsed with garbage through CALC and most of OUT.
    send_frame(f_unit, -1, 0, acc);
    for (int k = 0; k < 12; k++) begin
      in_en = 1'b1;
      x_in  = 32'hFFFF_0000;
      check($sformatf("busy_in_ready_%0d", k), int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_en = 1'b0;
    x_in  = '0;
    expect_frame(e_unit, "ignored", acc);

    // Reset while b_6 is on the output.
    send_frame(f_ones, -1, 0, acc);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("pre_rst_valid", int'(out_valid), 1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("pre_rst_b6", int'($signed(b_out)), 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_b_out", int'(b_out), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    got.delete();
    gcyc.delete();
    @(posedge clk); #1;
    send_frame(f_unit, -1, 0, acc);
    expect_frame(e_unit, "post_rst", acc);

    // Back-to-back frames: second starts as soon as in_ready returns.
    send_frame(f_ones, -1, 0, acc1);
    send_frame(f_unit, -1, 0, acc2);
    expect_frame(e_ones, "b2b_first", acc1);
    expect_frame(e_unit, "b2b_second", acc2);

    repeat (5) @(posedge clk);
    #1;
    check("tail_no_extra", got.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
